hilo_mac: RTL and testbench

- Parametrised HI/LO register pair for the execute stage.
- Supports full writes, HI-only and LO-only writes (MTHI/MTLO), and multiply-accumulate/subtract ops (MADD/MADDU/MSUB/MSUBU).
- Accumulate ops run through a registered multiply stage, so {hi,lo} updates one cycle later. While an accumulate is in flight, a ready/valid handshake stalls the issuing stage.

---
 rtl/hilo_mac.sv | 120 ++++++++++++
 tb/tb_hilo_mac.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/hilo_mac.sv
// HI/LO register pair with MTHI/MTLO writes and a two-cycle multiply-accumulate path.
// Accumulate ops register the product first and fold it into {hi,lo} on the following edge.
module hilo_mac #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [2:0]       i_op,
  input  logic [WIDTH-1:0] i_hi,
  input  logic [WIDTH-1:0] i_lo,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_flush,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             o_busy
);

  // state   | meaning
  // IDLE    | ready; register writes commit directly, accumulates load the product
  // MUL     | product registered; fold into {hi,lo} next edge unless flushed

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } state_t;

  localparam logic [2:0] OP_NOP     = 3'd0;
  localparam logic [2:0] OP_WR_BOTH = 3'd1;
  localparam logic [2:0] OP_WR_HI   = 3'd2;
  localparam logic [2:0] OP_WR_LO   = 3'd3;

  state_t                 state_q, state_d;
  logic [WIDTH-1:0]       hi_q, hi_d;
  logic [WIDTH-1:0]       lo_q, lo_d;
  logic [2*WIDTH-1:0]     prod_q, prod_d;
  logic                   sub_q, sub_d;

  logic                   accept;
  logic                   op_signed;
  logic [2*WIDTH-1:0]     a_ext;
  logic [2*WIDTH-1:0]     b_ext;
  logic [2*WIDTH-1:0]     acc;
  logic [2*WIDTH-1:0]     acc_next;

  // Ops 4/6 are signed, 5/7 unsigned; the low 2*WIDTH bits of the extended
  // product are the exact result in both cases.
  assign op_signed = ~i_op[0];
  assign a_ext     = op_signed ? {{WIDTH{i_a[WIDTH-1]}}, i_a} : {{WIDTH{1'b0}}, i_a};
  assign b_ext     = op_signed ? {{WIDTH{i_b[WIDTH-1]}}, i_b} : {{WIDTH{1'b0}}, i_b};

  assign acc      = {hi_q, lo_q};
  assign acc_next = sub_q ? (acc - prod_q) : (acc + prod_q);

  assign o_ready = (state_q == ST_IDLE);
  assign o_busy  = (state_q == ST_MUL);
  assign accept  = i_valid && (state_q == ST_IDLE) && !i_flush;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      hi_q    <= '0;
      lo_q    <= '0;
      prod_q  <= '0;
      sub_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      prod_q  <= prod_d;
      sub_q   <= sub_d;
    end
  end

  always_comb begin
    state_d = state_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    prod_d  = prod_q;
    sub_d   = sub_q;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (i_op[2]) begin
            prod_d  = a_ext * b_ext;
            sub_d   = i_op[1];
            state_d = ST_MUL;
          end else begin
            case (i_op)
              OP_WR_BOTH: begin
                hi_d = i_hi;
                lo_d = i_lo;
              end
              OP_WR_HI: hi_d = i_hi;
              OP_WR_LO: lo_d = i_lo;
              OP_NOP:   ;
              default:  ;
            endcase
          end
        end
      end

      ST_MUL: begin
        state_d = ST_IDLE;
        if (!i_flush) begin
          {hi_d, lo_d} = acc_next;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  assign hi = hi_q;
  assign lo = lo_q;

endmodule

// File: tb/tb_hilo_mac.sv
// Directed bench for hilo_mac: writes, signed/unsigned accumulate, stall, flush and reset.
`timescale 1ns/1ps
module tb_hilo_mac;

  localparam int W = 32;

  logic         clk;
  logic         rst;
  logic         i_valid;
  logic         o_ready;
  logic [2:0]   i_op;
  logic [W-1:0] i_hi, i_lo, i_a, i_b;
  logic         i_flush;
  logic [W-1:0] hi, lo;
  logic         o_busy;

  int checks = 0;
  int errors = 0;

  hilo_mac #(.WIDTH(W)) dut (
    .clk     (clk),
    .rst     (rst),
    .i_valid (i_valid),
    .o_ready (o_ready),
    .i_op    (i_op),
    .i_hi    (i_hi),
    .i_lo    (i_lo),
    .i_a     (i_a),
    .i_b     (i_b),
    .i_flush (i_flush),
    .hi      (hi),
    .lo      (lo),
    .o_busy  (o_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_state(input string tag, input logic [31:0] ehi, input logic [31:0] elo,
                           input logic erdy);
    chk({tag, "_hi"}, {32'h0, hi}, {32'h0, ehi});
    chk({tag, "_lo"}, {32'h0, lo}, {32'h0, elo});
    chk({tag, "_rdy"}, {63'h0, o_ready}, {63'h0, erdy});
    chk({tag, "_busy"}, {63'h0, o_busy}, {63'h0, ~erdy});
  endtask

  // Present one op for one clock edge, then sample 1ns after the edge.
  task automatic step(input logic v, input logic [2:0] op, input logic [31:0] h,
                      input logic [31:0] l, input logic [31:0] a, input logic [31:0] b,
                      input logic fl);
    i_valid = v;
    i_op    = op;
    i_hi    = h;
    i_lo    = l;
    i_a     = a;
    i_b     = b;
    i_flush = fl;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    step(1'b0, 3'd0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0);
  endtask

  task automatic wr_both(input logic [31:0] h, input logic [31:0] l);
    step(1'b1, 3'd1, h, l, 32'h0, 32'h0, 1'b0);
  endtask

  initial begin
    rst = 1'b1;
    i_valid = 1'b0; i_op = 3'd0; i_hi = '0; i_lo = '0; i_a = '0; i_b = '0; i_flush = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk_state("reset", 32'h0, 32'h0, 1'b1);

    wr_both(32'h12345678, 32'h9ABCDEF0);
    chk_state("wr_both", 32'h12345678, 32'h9ABCDEF0, 1'b1);

    wr_both(32'h11111111, 32'h22222222);
    step(1'b1, 3'd2, 32'hAAAAAAAA, 32'hFFFF0000, 32'h0, 32'h0, 1'b0);
    chk_state("wr_hi", 32'hAAAAAAAA, 32'h22222222, 1'b1);
    step(1'b1, 3'd3, 32'h00001234, 32'h00000005, 32'h0, 32'h0, 1'b0);
    chk_state("wr_lo", 32'hAAAAAAAA, 32'h00000005, 1'b1);

    step(1'b1, 3'd0, 32'h77777777, 32'h77777777, 32'h0, 32'h0, 1'b0);
    chk_state("nop", 32'hAAAAAAAA, 32'h00000005, 1'b1);

    // MADD -1*2 onto 5
    wr_both(32'h0, 32'h5);
    step(1'b1, 3'd4, 32'h0, 32'h0, 32'hFFFFFFFF, 32'h2, 1'b0);
    chk_state("madd_busy", 32'h0, 32'h5, 1'b0);
    idle();
    chk_state("madd", 32'h0, 32'h3, 1'b1);

    wr_both(32'h0, 32'h5);
    step(1'b1, 3'd5, 32'h0, 32'h0, 32'hFFFFFFFF, 32'h2, 1'b0);
    idle();
    chk_state("maddu", 32'h2, 32'h3, 1'b1);

    wr_both(32'h0, 32'h0);
    step(1'b1, 3'd7, 32'h0, 32'h0, 32'hFFFFFFFF, 32'h2, 1'b0);
    idle();
    chk_state("msubu_wrap", 32'hFFFFFFFE, 32'h00000002, 1'b1);

    wr_both(32'h0, 32'h0);
    step(1'b1, 3'd6, 32'h0, 32'h0, 32'h3, 32'hFFFFFFFC, 1'b0);
    idle();
    chk_state("msub", 32'h0, 32'hC, 1'b1);

    // most-negative multiplicand, signed vs unsigned
    wr_both(32'h0, 32'h0);
    step(1'b1, 3'd4, 32'h0, 32'h0, 32'h80000000, 32'h1, 1'b0);
    idle();
    chk_state("madd_minneg", 32'hFFFFFFFF, 32'h80000000, 1'b1);
    wr_both(32'h0, 32'h0);
    step(1'b1, 3'd5, 32'h0, 32'h0, 32'h80000000, 32'h3, 1'b0);
    idle();
    chk_state("maddu_big", 32'h1, 32'h80000000, 1'b1);

    // Back-to-back: accumulate into a nonzero hi
    step(1'b1, 3'd6, 32'h0, 32'h0, 32'h2, 32'h2, 1'b0);
    idle();
    chk_state("msub_acc", 32'h1, 32'h7FFFFFFC, 1'b1);

    // Stall: WR_BOTH presented during MUL is ignored, then accepted when held
    wr_both(32'h0, 32'h0);
    step(1'b1, 3'd4, 32'h0, 32'h0, 32'h2, 32'h3, 1'b0);
    chk_state("stall_busy", 32'h0, 32'h0, 1'b0);
    wr_both(32'h0000DEAD, 32'h0000BEEF);
    chk_state("stall_ignored", 32'h0, 32'h6, 1'b1);
    wr_both(32'h0000DEAD, 32'h0000BEEF);
    chk_state("stall_accepted", 32'h0000DEAD, 32'h0000BEEF, 1'b1);

    // Flush in MUL cancels the commit
    wr_both(32'h0, 32'h1);
    step(1'b1, 3'd4, 32'h0, 32'h0, 32'h2, 32'h3, 1'b0);
    step(1'b0, 3'd0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b1);
    chk_state("flush_mul", 32'h0, 32'h1, 1'b1);
    idle();
    chk_state("flush_after", 32'h0, 32'h1, 1'b1);

    // Flush in IDLE blocks acceptance
    step(1'b1, 3'd1, 32'h5555, 32'h6666, 32'h0, 32'h0, 1'b1);
    chk_state("flush_idle_wr", 32'h0, 32'h1, 1'b1);
    step(1'b1, 3'd4, 32'h0, 32'h0, 32'h2, 32'h3, 1'b1);
    chk_state("flush_idle_madd", 32'h0, 32'h1, 1'b1);

    // Reset during MUL discards the pending accumulate
    wr_both(32'h7, 32'h1);
    step(1'b1, 3'd4, 32'h0, 32'h0, 32'h2, 32'h3, 1'b0);
    rst = 1'b1;
    idle();
    rst = 1'b0;
    chk_state("rst_mul", 32'h0, 32'h0, 1'b1);
    idle();
    chk_state("rst_after", 32'h0, 32'h0, 1'b1);

    // Product register was cleared by reset: a flushed-free MUL commit uses fresh P
    step(1'b1, 3'd5, 32'h0, 32'h0, 32'h4, 32'h5, 1'b0);
    idle();
    chk_state("post_rst_maddu", 32'h0, 32'h14, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
